alu_op_scheduler: RTL and testbench
===================================

// Module: alu_op_scheduler
// PURPOSE
// - Shares one ALU execution unit (ADD/XOR/MUL/AND) between N_REQ requesters.
// - Round-robin arbitration.
// - One operation in flight; each operation is sequenced IDLE->EXEC->RESP.
// - Sits between the bus-side command sources and the ALU datapath the core test suite targets.
// PARAMETERS
// N_REQ    4  number of requesters (2..8)
// WIDTH    8  operand width in bits
// MUL_LAT  3  EXEC cycles for MUL (>=1); ADD/XOR/AND take 1 EXEC cycle
// PORTS
// clk         in   1            clock; all state on rising edge
// rst         in   1            asynchronous, active-high reset
// req_valid   in   N_REQ        per-requester command valid
// req_ready   out  N_REQ        per-requester accept (one-hot or zero)
// req_op      in   2*N_REQ      opcode per requester: 0 ADD, 1 XOR, 2 MUL, 3 AND
// req_a       in   N_REQ*WIDTH  operand A per requester
// req_b       in   N_REQ*WIDTH  operand B per requester
// rsp_valid   out  1            result valid
// rsp_ready   in   1            result consumer accept
// rsp_id      out  $clog2(N_REQ) index of the requester that owns the result
// rsp_op      out  2            opcode of the result
// rsp_result  out  2*WIDTH      result
// busy        out  1            1 whenever state != IDLE
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-high (port rst), clock port clk.
// - Reset values:
//   - req_ready=0, rsp_valid=0, rsp_id=0, rsp_op=0, rsp_result=0, busy=0.
//   - state=IDLE, rr_ptr=0.
// - FSM:
//   - IDLE: if any req_valid, grant the first requester at or after rr_ptr (modulo N_REQ).
//     - req_ready[g]=1 combinationally in the same cycle (handshake = valid&ready).
//     - Latch op/a/b and g; rr_ptr <= g+1 mod N_REQ; go to EXEC.
//   - EXEC: cycle counter runs from 0.
//     - Leave EXEC after 1 cycle (ADD/XOR/AND) or MUL_LAT cycles (MUL).
//     - On leaving, register the result and go to RESP.
//   - RESP: rsp_valid=1 and rsp_* held stable until rsp_valid&rsp_ready.
//     - Then go to IDLE.
//     - No new grant in that same cycle; the next grant is earliest in the following cycle.
// - req_ready is 0 in EXEC and RESP. Requesters must hold valid/op/a/b until granted.
// - Latency from grant to rsp_valid rising: 2 cycles (ADD/XOR/AND), MUL_LAT+1 cycles (MUL).
// - Arithmetic (operands unsigned):
//   - ADD: {WIDTH-1 zeros, carry, sum}, i.e. a WIDTH+1-bit sum zero-extended.
//   - XOR/AND: bitwise result, zero-extended.
//   - MUL: full 2*WIDTH-bit product.
// - Boundaries:
//   - No requests: stay IDLE and hold rr_ptr.
//   - All requesters valid: grants cycle through every index in order; no starvation.
//   - Max wait: N_REQ-1 operations ahead of a requester.
//   - rr_ptr wraps from N_REQ-1 to 0.
//   - rsp_ready held low: stay in RESP indefinitely; outputs stable; no grants.
//   - req_valid dropped before grant: no grant, no response, rr_ptr unchanged.
//   - Reset asserted mid-EXEC/RESP: operation discarded, no response, all outputs return to reset values immediately.
//   - Illegal rsp_ready without rsp_valid: ignored.
// STRUCTURE
// - Shared package alu_sched_pkg:
//   - typedef enum logic[1:0] {OP_ADD, OP_XOR, OP_MUL, OP_AND} alu_op_e (also used by the test sequence items).
//   - typedef enum {S_IDLE, S_EXEC, S_RESP} sched_state_e.
//   - Function op_latency(op, MUL_LAT).
// - Sub-module rr_arbiter #(N_REQ):
//   - Inputs: req vector, rr_ptr.
//   - Outputs: one-hot grant and encoded index.
//   - Purely combinational.
// - Top: FSM, operand latches, EXEC counter, result compute and register.
// TESTING
// T1 single ADD: N_REQ=4, WIDTH=8, req0 op=ADD a=8'hF0 b=8'h20
//    -> grant cycle 0; rsp_valid at cycle 2; rsp_id=0, rsp_result=16'h0110.
// T2 MUL latency: req2 op=MUL a=8'hFF b=8'hFF, MUL_LAT=3
//    -> rsp_valid at grant+4; rsp_result=16'hFE01; rsp_id=2.
// T3 fairness: all 4 requesters valid continuously with XOR, rsp_ready=1
//    -> grant order 0,1,2,3,0,...; each grant 3 cycles apart.
// T4 backpressure: AND a=8'h3C b=8'h0F, rsp_ready=0 for 5 cycles
//    -> rsp_valid held with result 16'h000C; req1 not granted until one cycle after the handshake.
// T5 reset mid-MUL: assert rst in EXEC cycle 1
//    -> all outputs 0 at once, no rsp_valid after release, next grant starts from req0.
// T6 wrap: only req3, then req0 valid
//    -> rr_ptr 3->0; req0 granted next with rsp_id=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU operation scheduler: opcodes, FSM states and EXEC latency.
package alu_sched_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_XOR, OP_MUL, OP_AND} alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} sched_state_e;

  // Number of EXEC cycles an opcode occupies the shared unit.
  function automatic int op_latency(alu_op_e op, int mul_lat);
    return (op == OP_MUL) ? mul_lat : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  // Scan offsets from farthest to nearest so the nearest hit wins the last assignment.
  always_comb begin : arb
    int j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = IDW'(j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU (ADD/XOR/MUL/AND) among N_REQ requesters; round-robin grant,
// one operation in flight, sequenced IDLE -> EXEC -> RESP.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3,
  localparam int IDW = $clog2(N_REQ),
  localparam int CW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ-1:0][1:0]       i_req_op,
  input  logic [N_REQ-1:0][WIDTH-1:0] i_req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] i_req_b,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [IDW-1:0]              o_rsp_id,
  output logic [1:0]                  o_rsp_op,
  output logic [2*WIDTH-1:0]          o_rsp_result,
  output logic                        o_busy
);

  sched_state_e r_state, w_state_nxt;

  logic [IDW-1:0]     r_ptr, r_id;
  alu_op_e            r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CW-1:0]      r_cnt;
  logic [IDW-1:0]     r_rsp_id;
  logic [1:0]         r_rsp_op;
  logic [2*WIDTH-1:0] r_rsp_result;

  logic [N_REQ-1:0]   w_gnt;
  logic [IDW-1:0]     w_idx;
  logic               w_any, w_grant, w_exec_done;
  logic [2*WIDTH-1:0] w_result;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_exec_done = (int'(r_cnt) == op_latency(r_op, MUL_LAT) - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant only from IDLE, so the RESP->IDLE cycle never carries a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    o_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          o_req_ready = w_gnt;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  if (w_exec_done) w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ADD is a WIDTH+1 bit sum zero-extended; operands are unsigned throughout.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = (2*WIDTH)'(r_a) + (2*WIDTH)'(r_b);
      OP_XOR:  w_result = (2*WIDTH)'(r_a ^ r_b);
      OP_MUL:  w_result = (2*WIDTH)'(r_a) * (2*WIDTH)'(r_b);
      OP_AND:  w_result = (2*WIDTH)'(r_a & r_b);
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_op         <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_rsp_id     <= '0;
      r_rsp_op     <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_grant) begin
        r_op  <= alu_op_e'(i_req_op[w_idx]);
        r_a   <= i_req_a[w_idx];
        r_b   <= i_req_b[w_idx];
        r_id  <= w_idx;
        r_cnt <= '0;
        r_ptr <= (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == S_EXEC) begin
        if (w_exec_done) begin
          r_rsp_id     <= r_id;
          r_rsp_op     <= r_op;
          r_rsp_result <= w_result;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_busy       = (r_state != S_IDLE);
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_result = r_rsp_result;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: vector table plus response scoreboard.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req_valid, req_ready;
  logic [N-1:0][1:0]   req_op;
  logic [N-1:0][W-1:0] req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [1:0]          rsp_id, rsp_op;
  logic [2*W-1:0]      rsp_result;
  logic                busy;

  always #5 clk = ~clk;

  alu_op_scheduler #(.N_REQ(N), .WIDTH(W), .MUL_LAT(ML)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_op     (rsp_op),
    .o_rsp_result (rsp_result),
    .o_busy       (busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [1:0]  op;
    logic [15:0] res;
  } sb_t;

  typedef struct {
    logic [1:0]  id;
    alu_op_e     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  sb_t sbq[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return {7'b0, {1'b0, a} + {1'b0, b}};
      2'd1:    return {8'b0, a ^ b};
      2'd2:    return 16'(a) * 16'(b);
      default: return {8'b0, a & b};
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] id, input logic [1:0] op, input logic [15:0] res);
    sb_t e;
    e.id = id; e.op = op; e.res = res;
    sbq.push_back(e);
  endtask

  // Scoreboard: every accepted response must match the oldest expectation.
  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_op", 32'(rsp_op), 32'(e.op));
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
      end
    end
  end

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) break;
    end
    chk("drain", 32'(sbq.size() == 0 && !busy), 32'd1);
  endtask

  // Single request: grant, latency from grant to rsp_valid, result via scoreboard.
  task automatic do_req(input logic [1:0] id, input alu_op_e op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
    logic ok;
    int   lat;
    @(posedge clk); #1;
    req_valid[id] = 1'b1; req_op[id] = op; req_a[id] = a; req_b[id] = b;
    wait_grant(ok);
    if (ok) begin
      chk("grant", 32'(req_ready), 32'(4'b0001 << id));
      push_exp(id, op, exp);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      lat = 1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rsp_valid) break;
        lat++;
      end
      chk("latency", 32'(lat), (op == OP_MUL) ? 32'(ML + 1) : 32'd2);
    end else req_valid[id] = 1'b0;
    drain();
  endtask

  vec_t tbl[10];

  initial begin : main
    logic ok;
    int   start, gcount, last_c, exp_idx, seen;

    tbl[0] = '{2'd0, OP_ADD, 8'hF0, 8'h20, 16'h0110};
    tbl[1] = '{2'd2, OP_MUL, 8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{2'd1, OP_AND, 8'h3C, 8'h0F, 16'h000C};
    tbl[3] = '{2'd3, OP_XOR, 8'hA5, 8'h5A, 16'h00FF};
    tbl[4] = '{2'd0, OP_ADD, 8'hFF, 8'hFF, 16'h01FE};
    tbl[5] = '{2'd1, OP_MUL, 8'h00, 8'hFF, 16'h0000};
    tbl[6] = '{2'd2, OP_MUL, 8'h12, 8'h34, 16'h03A8};
    tbl[7] = '{2'd3, OP_AND, 8'hFF, 8'h80, 16'h0080};
    tbl[8] = '{2'd1, OP_XOR, 8'hFF, 8'hFF, 16'h0000};
    tbl[9] = '{2'd2, OP_ADD, 8'h01, 8'h01, 16'h0002};

    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;  // ready without valid must be ignored

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_op", 32'(rsp_op), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 10; i++)
      do_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Fairness: all requesters valid; order starts after the last granted index.
    start = (int'(tbl[9].id) + 1) % N;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_op[i] = OP_XOR; req_a[i] = 8'(8'h11 * (i + 1)); req_b[i] = 8'hF0;
    end
    req_valid = '1;
    gcount = 0; last_c = -1;
    for (int c = 0; c < 60 && gcount < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        exp_idx = (start + gcount) % N;
        chk("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_idx));
        if (last_c >= 0) chk("rr_spacing", 32'(cyc - last_c), 32'd3);
        last_c = cyc;
        push_exp(2'(exp_idx), 2'd1, model(2'd1, req_a[exp_idx], req_b[exp_idx]));
        gcount++;
      end
    end
    chk("rr_count", 32'(gcount), 32'd8);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure: rr_ptr is back at 3, so req0 wins over req1.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_op[0] = OP_AND; req_a[0] = 8'h3C; req_b[0] = 8'h0F;
    req_op[1] = OP_XOR; req_a[1] = 8'h55; req_b[1] = 8'h0F;
    req_valid = 4'b0011;
    wait_grant(ok);
    chk("bp_grant0", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 2'd3, 16'h000C);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", 32'(rsp_result), 32'h000C);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_no_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_grant1_next", 32'(req_ready), 32'b0010);
    push_exp(2'd1, 2'd1, 16'h005A);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // Reset in EXEC cycle 1 of a MUL: discarded, pointer back to 0.
    @(posedge clk); #1;
    req_op[2] = OP_MUL; req_a[2] = 8'h10; req_b[2] = 8'h10;
    req_valid[2] = 1'b1;
    wait_grant(ok);
    chk("rst_mul_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_all", 32'({rsp_id, rsp_op, rsp_result}), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    @(posedge clk); #1;
    req_op[0] = OP_ADD; req_a[0] = 8'h7F; req_b[0] = 8'h01;
    req_op[3] = OP_XOR; req_a[3] = 8'h01; req_b[3] = 8'h02;
    req_valid = 4'b1001;
    wait_grant(ok);
    chk("postrst_grant0", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 2'd0, 16'h0080);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Wrap: req3 alone moves the pointer to 0, so req0 beats req1.
    do_req(2'd3, OP_XOR, 8'h0F, 8'hF0, 16'h00FF);
    @(posedge clk); #1;
    req_op[0] = OP_MUL; req_a[0] = 8'h03; req_b[0] = 8'h05;
    req_op[1] = OP_ADD; req_a[1] = 8'h01; req_b[1] = 8'h02;
    req_valid = 4'b0011;
    wait_grant(ok);
    chk("wrap_grant0", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 2'd2, 16'h000F);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
